// File: rtl/eeprom_pkg.sv
// Shared constants for the EEPROM arbiter: FSM encodings, GAP length and
// transfer-direction values.
package eeprom_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_WAIT_ACK = 2'd1;
  localparam state_t ST_GAP      = 2'd2;

  // Cycles spent in GAP so the serial engine can settle back to idle.
  localparam int GAP_LEN = 2;

  localparam logic DIR_READ  = 1'b1;
  localparam logic DIR_WRITE = 1'b0;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector. The grant is combinational from the request
// vector; the last-granted pointer advances only when the grant is accepted.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_gnt
);

  // Index of the requester granted most recently; 1 after reset so that
  // requester 0 wins the first contention.
  logic r_last;

  // Pick the winner: a lone requester wins, on a tie the one not granted last.
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  // Remember who won whenever a grant is actually taken.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= 1'b1;
    end else if (i_accept) begin
      r_last <= o_gnt[1];
    end
  end

endmodule

// File: rtl/eeprom_arbiter.sv
// Arbitrates two requesters onto a single serial EEPROM engine. One
// transaction is outstanding at a time: grant, wait for the engine ACK (or a
// timeout), then a fixed GAP before the next grant. All outputs are registered.
module eeprom_arbiter
  import eeprom_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int TIMEOUT = 1023
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [1:0]        REQ,
  input  logic [1:0]        REQ_RD,
  input  logic [ADDR_W-1:0] REQ_ADDR0,
  input  logic [ADDR_W-1:0] REQ_ADDR1,
  input  logic [7:0]        REQ_WDATA0,
  input  logic [7:0]        REQ_WDATA1,
  output logic [1:0]        GNT,
  output logic [1:0]        DONE,
  output logic              ERR,
  output logic [7:0]        RDATA,
  output logic              WR,
  output logic              RD,
  output logic [ADDR_W-1:0] ADDR,
  output logic [7:0]        WDATA,
  output logic              WDATA_OE,
  input  logic [7:0]        EE_RDATA,
  input  logic              ACK
);

  localparam int                  TIMER_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT);
  localparam logic [1:0]          GAP_LAST   = 2'(GAP_LEN - 1);

  state_t              r_state;
  logic [TIMER_W-1:0]  r_timer;
  logic [1:0]          r_gap;
  logic [1:0]          r_owner;
  logic                r_dir;
  logic [1:0]          r_gnt;
  logic [1:0]          r_done;
  logic                r_err;
  logic [7:0]          r_rdata;
  logic                r_wr;
  logic                r_rd;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_wdata;
  logic                r_oe;

  logic [1:0]          w_grant;
  logic                w_start;
  logic                w_sel_dir;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [7:0]          w_sel_wdata;

  // A grant can only be taken from IDLE; requests seen in other states wait.
  assign w_start     = (r_state == ST_IDLE) && (|REQ);
  assign w_sel_dir   = w_grant[1] ? REQ_RD[1]  : REQ_RD[0];
  assign w_sel_addr  = w_grant[1] ? REQ_ADDR1  : REQ_ADDR0;
  assign w_sel_wdata = w_grant[1] ? REQ_WDATA1 : REQ_WDATA0;

  rr_arb2 u_rr_arb2 (
    .i_clk    (CLK),
    .i_rst    (RESET),
    .i_req    (REQ),
    .i_accept (w_start),
    .o_gnt    (w_grant)
  );

  // Transaction FSM: grant/launch, wait for ACK or timeout, then settle in GAP.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_gap   <= '0;
      r_owner <= '0;
      r_dir   <= DIR_WRITE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_oe    <= 1'b0;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      r_err  <= 1'b0;
      r_wr   <= 1'b0;
      r_rd   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_gnt   <= w_grant;
            r_owner <= w_grant;
            r_dir   <= w_sel_dir;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_oe    <= (w_sel_dir == DIR_WRITE);
            r_wr    <= (w_sel_dir == DIR_WRITE);
            r_rd    <= (w_sel_dir == DIR_READ);
            r_timer <= '0;
            r_state <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          // ACK is checked first so a late ACK on the expiry cycle still succeeds.
          if (ACK) begin
            r_done  <= r_owner;
            if (r_dir == DIR_READ) begin
              r_rdata <= EE_RDATA;
            end
            r_oe    <= 1'b0;
            r_gap   <= '0;
            r_state <= ST_GAP;
          end else if (r_timer == TIMER_LAST) begin
            r_done  <= r_owner;
            r_err   <= 1'b1;
            r_oe    <= 1'b0;
            r_gap   <= '0;
            r_state <= ST_GAP;
          end else begin
            r_timer <= r_timer + TIMER_W'(1);
          end
        end
        ST_GAP: begin
          if (r_gap == GAP_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap <= r_gap + 2'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_oe    <= 1'b0;
        end
      endcase
    end
  end

  assign GNT      = r_gnt;
  assign DONE     = r_done;
  assign ERR      = r_err;
  assign RDATA    = r_rdata;
  assign WR       = r_wr;
  assign RD       = r_rd;
  assign ADDR     = r_addr;
  assign WDATA    = r_wdata;
  assign WDATA_OE = r_oe;

endmodule

// File: tb/tb_eeprom_arbiter.sv
// Bench for eeprom_arbiter: directed scenarios followed by a randomized run
// checked against a transaction-level timing model.
module tb_eeprom_arbiter;

  localparam int ADDR_W  = 11;
  localparam int TIMEOUT = 8;

  logic              CLK = 1'b0;
  logic              RESET = 1'b0;
  logic [1:0]        REQ = '0;
  logic [1:0]        REQ_RD = '0;
  logic [ADDR_W-1:0] REQ_ADDR0 = '0;
  logic [ADDR_W-1:0] REQ_ADDR1 = '0;
  logic [7:0]        REQ_WDATA0 = '0;
  logic [7:0]        REQ_WDATA1 = '0;
  logic [7:0]        EE_RDATA = '0;
  logic              ACK = 1'b0;
  logic [1:0]        GNT;
  logic [1:0]        DONE;
  logic              ERR;
  logic [7:0]        RDATA;
  logic              WR;
  logic              RD;
  logic [ADDR_W-1:0] ADDR;
  logic [7:0]        WDATA;
  logic              WDATA_OE;

  logic [7:0] ctl;
  assign ctl = {GNT, DONE, ERR, WR, RD, WDATA_OE};

  int total = 0;
  int bad   = 0;

  eeprom_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .REQ        (REQ),
    .REQ_RD     (REQ_RD),
    .REQ_ADDR0  (REQ_ADDR0),
    .REQ_ADDR1  (REQ_ADDR1),
    .REQ_WDATA0 (REQ_WDATA0),
    .REQ_WDATA1 (REQ_WDATA1),
    .GNT        (GNT),
    .DONE       (DONE),
    .ERR        (ERR),
    .RDATA      (RDATA),
    .WR         (WR),
    .RD         (RD),
    .ADDR       (ADDR),
    .WDATA      (WDATA),
    .WDATA_OE   (WDATA_OE),
    .EE_RDATA   (EE_RDATA),
    .ACK        (ACK)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #2 RESET = 1'b1;
    #1;
    total++; if (ctl !== 8'h00) begin bad++; $display("FAIL reset_ctl got=%b want=%b", ctl, 8'h00); end
    total++; if (ADDR !== '0) begin bad++; $display("FAIL reset_addr got=%h want=0", ADDR); end
    total++; if (WDATA !== 8'h00 || RDATA !== 8'h00) begin bad++; $display("FAIL reset_data got=%h/%h want=00/00", WDATA, RDATA); end
    tick();
    RESET = 1'b0;
    total++; if (ctl !== 8'h00) begin bad++; $display("FAIL reset_hold_ctl got=%b want=%b", ctl, 8'h00); end
  endtask

  task automatic test_single_write();
    REQ_ADDR0 = 11'h2A5; REQ_WDATA0 = 8'h3C; REQ_RD = 2'b00; REQ = 2'b01;
    tick();
    total++; if (ctl !== {2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1}) begin bad++; $display("FAIL wr_grant_ctl got=%b want=%b", ctl, {2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1}); end
    total++; if (ADDR !== 11'h2A5 || WDATA !== 8'h3C) begin bad++; $display("FAIL wr_grant_bus got=%h/%h want=2a5/3c", ADDR, WDATA); end
    REQ = 2'b00; REQ_WDATA0 = 8'hFF; REQ_ADDR0 = 11'h000;
    tick();
    total++; if (ctl !== 8'b0000_0001) begin bad++; $display("FAIL wr_wait_ctl got=%b want=%b", ctl, 8'b0000_0001); end
    total++; if (ADDR !== 11'h2A5 || WDATA !== 8'h3C) begin bad++; $display("FAIL wr_hold_bus got=%h/%h want=2a5/3c", ADDR, WDATA); end
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    total++; if (ctl !== {2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0}) begin bad++; $display("FAIL wr_done_ctl got=%b want=%b", ctl, {2'b00, 2'b01, 4'b0000}); end
    tick();
    total++; if (ctl !== 8'h00) begin bad++; $display("FAIL wr_gap_ctl got=%b want=%b", ctl, 8'h00); end
    tick();
  endtask

  task automatic test_single_read();
    REQ_ADDR1 = 11'h001; REQ_RD = 2'b10; REQ = 2'b10;
    tick();
    total++; if (ctl !== {2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0}) begin bad++; $display("FAIL rd_grant_ctl got=%b want=%b", ctl, {2'b10, 2'b00, 4'b0010}); end
    total++; if (ADDR !== 11'h001) begin bad++; $display("FAIL rd_grant_addr got=%h want=001", ADDR); end
    REQ = 2'b00; EE_RDATA = 8'hA7; ACK = 1'b1;
    tick();
    ACK = 1'b0; EE_RDATA = 8'h00;
    total++; if (ctl !== {2'b00, 2'b10, 4'b0000}) begin bad++; $display("FAIL rd_done_ctl got=%b want=%b", ctl, {2'b00, 2'b10, 4'b0000}); end
    total++; if (RDATA !== 8'hA7) begin bad++; $display("FAIL rd_rdata got=%h want=a7", RDATA); end
    ACK = 1'b1; EE_RDATA = 8'h55;
    tick();
    total++; if (ctl !== 8'h00) begin bad++; $display("FAIL rd_gap_ack1 got=%b want=%b", ctl, 8'h00); end
    tick();
    total++; if (ctl !== 8'h00 || RDATA !== 8'hA7) begin bad++; $display("FAIL rd_gap_ack2 got=%b/%h want=00000000/a7", ctl, RDATA); end
    ACK = 1'b0; EE_RDATA = 8'h00;
  endtask

  task automatic test_contention();
    logic [1:0] exp_g [3];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
    REQ_RD = 2'b00; REQ_ADDR0 = 11'h100; REQ_ADDR1 = 11'h200; REQ = 2'b11;
    for (int t = 0; t < 3; t++) begin
      tick();
      total++; if (GNT !== exp_g[t]) begin bad++; $display("FAIL cont_grant%0d got=%b want=%b", t, GNT, exp_g[t]); end
      total++; if (ADDR !== (exp_g[t][1] ? 11'h200 : 11'h100)) begin bad++; $display("FAIL cont_addr%0d got=%h", t, ADDR); end
      tick();
      ACK = 1'b1;
      tick();
      ACK = 1'b0;
      total++; if (DONE !== exp_g[t]) begin bad++; $display("FAIL cont_done%0d got=%b want=%b", t, DONE, exp_g[t]); end
      tick();
      total++; if (GNT !== 2'b00) begin bad++; $display("FAIL cont_gap1_%0d got=%b want=00", t, GNT); end
      tick();
      total++; if (GNT !== 2'b00) begin bad++; $display("FAIL cont_gap2_%0d got=%b want=00", t, GNT); end
    end
    REQ = 2'b00;
  endtask

  task automatic test_timeout();
    REQ_RD = 2'b00; REQ = 2'b10;
    tick();
    total++; if (GNT !== 2'b10) begin bad++; $display("FAIL to_grant got=%b want=10", GNT); end
    REQ = 2'b00;
    for (int k = 1; k <= TIMEOUT + 1; k++) begin
      tick();
      if (k <= TIMEOUT) begin
        total++; if (DONE !== 2'b00) begin bad++; $display("FAIL to_early_done k=%0d got=%b want=00", k, DONE); end
      end else begin
        total++; if (ctl !== {2'b00, 2'b10, 1'b1, 3'b000}) begin bad++; $display("FAIL to_done_ctl got=%b want=%b", ctl, {2'b00, 2'b10, 1'b1, 3'b000}); end
        total++; if (RDATA !== 8'hA7) begin bad++; $display("FAIL to_rdata got=%h want=a7", RDATA); end
      end
    end
    REQ = 2'b01;
    tick();
    total++; if (GNT !== 2'b00) begin bad++; $display("FAIL to_gap1 got=%b want=00", GNT); end
    tick();
    total++; if (GNT !== 2'b00) begin bad++; $display("FAIL to_gap2 got=%b want=00", GNT); end
    tick();
    total++; if (GNT !== 2'b01) begin bad++; $display("FAIL to_next_grant got=%b want=01", GNT); end
    REQ = 2'b00; ACK = 1'b1;
    tick();
    ACK = 1'b0;
    total++; if (DONE !== 2'b01 || ERR !== 1'b0) begin bad++; $display("FAIL to_next_done got=%b/%b want=01/0", DONE, ERR); end
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    REQ_ADDR1 = 11'h7FF; REQ_WDATA1 = 8'h81; REQ_RD = 2'b00; REQ = 2'b10;
    tick();
    total++; if (GNT !== 2'b10) begin bad++; $display("FAIL rst_mid_grant got=%b want=10", GNT); end
    REQ = 2'b00;
    tick();
    #2 RESET = 1'b1;
    #1;
    total++; if (ctl !== 8'h00 || ADDR !== '0) begin bad++; $display("FAIL rst_mid_async got=%b/%h want=00000000/000", ctl, ADDR); end
    total++; if (WDATA !== 8'h00 || RDATA !== 8'h00) begin bad++; $display("FAIL rst_mid_data got=%h/%h want=00/00", WDATA, RDATA); end
    ACK = 1'b1;
    tick();
    total++; if (DONE !== 2'b00) begin bad++; $display("FAIL rst_mid_done got=%b want=00", DONE); end
    RESET = 1'b0; ACK = 1'b0; REQ = 2'b11;
    tick();
    total++; if (GNT !== 2'b01) begin bad++; $display("FAIL rst_mid_regrant got=%b want=01", GNT); end
    REQ = 2'b00; ACK = 1'b1;
    tick();
    ACK = 1'b0;
    total++; if (DONE !== 2'b01) begin bad++; $display("FAIL rst_mid_redone got=%b want=01", DONE); end
    tick();
    tick();
  endtask

  // Transaction-level model: a grant happens whenever the arbiter is free and
  // someone is pending; completion falls on the ACK edge or TIMEOUT+1 edges
  // after the grant; the arbiter is free again three edges after completion.
  task automatic test_random();
    bit               busy = 1'b0;
    int               free_edge = 0;
    int               done_edge = 0;
    int               ack_edge = -1;
    bit               done_err = 1'b0;
    int               owner = 0;
    int               m_last = 1;
    int               d;
    bit               own_rd = 1'b0;
    bit [1:0]         pend = 2'b00;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [7:0]       m_wdata = '0;
    logic [7:0]       m_rdata = '0;
    logic [1:0]       eg, ed;
    logic             ee, ew, er, eo;
    REQ = 2'b00; ACK = 1'b0;
    #1 RESET = 1'b1;
    tick();
    RESET = 1'b0;
    for (int e = 0; e < 400; e++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          REQ_RD[i] = 1'($urandom_range(0, 1));
          if (i == 0) begin REQ_ADDR0 = ADDR_W'($urandom); REQ_WDATA0 = 8'($urandom); end
          else begin REQ_ADDR1 = ADDR_W'($urandom); REQ_WDATA1 = 8'($urandom); end
        end
      end
      REQ = pend;
      EE_RDATA = 8'($urandom);
      if (busy) ACK = (e == ack_edge);
      else ACK = ($urandom_range(0, 3) == 0);
      eg = 2'b00; ed = 2'b00; ee = 1'b0;
      if (!busy && e >= free_edge && pend != 2'b00) begin
        owner = (pend == 2'b11) ? ((m_last == 1) ? 0 : 1) : (pend[0] ? 0 : 1);
        m_last = owner;
        own_rd = REQ_RD[owner];
        m_addr = (owner == 1) ? REQ_ADDR1 : REQ_ADDR0;
        m_wdata = (owner == 1) ? REQ_WDATA1 : REQ_WDATA0;
        eg = 2'(1 << owner);
        pend[owner] = 1'b0;
        d = $urandom_range(1, 12);
        if (d <= TIMEOUT + 1) begin ack_edge = e + d; done_edge = e + d; done_err = 1'b0; end
        else begin ack_edge = -1; done_edge = e + TIMEOUT + 1; done_err = 1'b1; end
        busy = 1'b1;
      end else if (busy && e == done_edge) begin
        ed = 2'(1 << owner);
        ee = done_err;
        if (!done_err && own_rd) m_rdata = EE_RDATA;
        busy = 1'b0;
        free_edge = e + 3;
      end
      ew = (eg != 2'b00) && !own_rd;
      er = (eg != 2'b00) && own_rd;
      eo = busy && !own_rd;
      tick();
      REQ = pend;
      total++; if (ctl !== {eg, ed, ee, ew, er, eo}) begin bad++; $display("FAIL rand_ctl e=%0d got=%b want=%b", e, ctl, {eg, ed, ee, ew, er, eo}); end
      total++; if (RDATA !== m_rdata) begin bad++; $display("FAIL rand_rdata e=%0d got=%h want=%h", e, RDATA, m_rdata); end
      if (busy) begin
        total++; if (ADDR !== m_addr || WDATA !== m_wdata) begin bad++; $display("FAIL rand_bus e=%0d got=%h/%h want=%h/%h", e, ADDR, WDATA, m_addr, m_wdata); end
      end
    end
    REQ = 2'b00; ACK = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
